// File: rtl/wb_sram_slave_pkg.sv
// Shared Wishbone B4 definitions: cycle-type/burst-type codes, target FSM states
// and the registered-feedback burst address sequencer.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } wb_state_e;

  // Only CONST and INCR keep a burst alive; EOB, CLASSIC and reserved codes end it.
  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

  // Callers truncate the result to their index width, which gives the
  // modulo-depth wrap of linear bursts for free.
  function automatic logic [31:0] wb_next_idx(input logic [31:0] idx,
                                              input logic [2:0]  cti,
                                              input logic [1:0]  bte);
    logic [31:0] nxt;
    nxt = idx;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: nxt = idx + 32'd1;
        BTE_WRAP4:  nxt = {idx[31:2], idx[1:0] + 2'd1};
        BTE_WRAP8:  nxt = {idx[31:3], idx[2:0] + 3'd1};
        default:    nxt = {idx[31:4], idx[3:0] + 4'd1};
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            cyc;
  logic            stb;
  logic            we;
  logic            ack;
  logic            err;

  modport master (
    output adr, cti, bte, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cti, bte, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_slave_mem.sv
// Byte-enabled synchronous RAM: one write port, one registered read port,
// write-first when both touch the same word in the same cycle.
module wb_sram_slave_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wsel,
  output logic [DATA_W-1:0]   q
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_merged;

  always_comb begin
    wr_merged = mem[raddr];
    for (int b = 0; b < NB; b++) begin
      if (wsel[b]) wr_merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wsel[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) q <= (we && (waddr == raddr)) ? wr_merged : mem[raddr];
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM target (classic cycles and CTI/BTE bursts).
// Define WB_SRAM_RANGE_CHK_EN to answer out-of-window accesses with ERR.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       MEM_DEPTH     = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE      = '0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int BYTES    = WB_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

`ifdef WB_SRAM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  // One extra bit keeps the upper bound from overflowing when the window ends at the top of the map.
  localparam logic [WB_ADDR_WIDTH:0] RANGE_LO = {1'b0, MEM_BASE};
  localparam logic [WB_ADDR_WIDTH:0] RANGE_HI =
    RANGE_LO + (WB_ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  wb_state_e                state;
  logic [IDX_W-1:0]         cur_idx;
  logic [IDX_W-1:0]         adr_idx;
  logic [IDX_W-1:0]         nxt_idx;
  logic [WB_ADDR_WIDTH:0]   adr_ext;
  logic                     oor;
  logic                     beat;
  logic                     rsp_ack;
  logic                     rsp_err;

  logic                     mem_re;
  logic                     mem_we;
  logic [IDX_W-1:0]         mem_raddr;
  logic [WB_DATA_WIDTH-1:0] mem_q;

  assign adr_idx = s.adr[ADDR_LSB +: IDX_W];
  assign adr_ext = {1'b0, s.adr};
  assign oor     = RANGE_CHK && ((adr_ext < RANGE_LO) || (adr_ext >= RANGE_HI));
  assign beat    = s.cyc & s.stb;
  assign nxt_idx = IDX_W'(wb_next_idx(32'(cur_idx), s.cti, s.bte));

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_raddr = adr_idx;
    case (state)
      IDLE:   mem_re = beat;
      SINGLE: mem_we = beat & s.we & ~oor;
      BURST: begin
        // Prefetch the next beat's word while this beat is being written.
        mem_re    = beat & ~oor;
        mem_we    = beat & s.we & ~oor;
        mem_raddr = nxt_idx;
      end
      default: ;
    endcase
  end

  wb_sram_slave_mem #(
    .DATA_W (WB_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .re    (mem_re),
    .raddr (mem_raddr),
    .we    (mem_we),
    .waddr (cur_idx),
    .wdata (s.dat_w),
    .wsel  (s.sel),
    .q     (mem_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cur_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            cur_idx <= adr_idx;
            state   <= is_burst_cti(s.cti) ? BURST : SINGLE;
          end
        end
        SINGLE: state <= IDLE;
        BURST: begin
          if (!s.cyc) begin
            state <= IDLE;
          end else if (s.stb) begin
            cur_idx <= nxt_idx;
            if (oor || !is_burst_cti(s.cti)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_ack = beat & ~oor & (state != IDLE);
  assign rsp_err = beat &  oor & (state != IDLE);

  // Gating on IDLE gives the asynchronous zero on reset without resetting the RAM output register.
  assign s.ack   = rsp_ack;
  assign s.err   = rsp_err;
  assign s.dat_r = ((state == IDLE) || rsp_err) ? '0 : mem_q;

endmodule
